// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFO drain / serializer path.
package fifo_drain_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {IDLE, READ, CAPT, SHIFT} drain_state_e;

endpackage

// File: rtl/fifo_drain_serializer_piso_shreg.sv
// Parallel-in serial-out shift register: load wins over shift, MSB presented on msb.
module piso_shreg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift_en) begin
      shreg <= shreg << 1;
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops words from a synchronous FIFO and shifts them out MSB-first over a valid/ready bit stream.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  ser_out,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  underflow_err,
  input  logic                  err_clr
);

  localparam int unsigned BCW = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;

  drain_state_e   state;
  logic [BCW-1:0] bit_cnt;
  logic           handshake;
  logic           load;

  assign handshake = (state == SHIFT) && ser_valid && ser_ready;
  assign load      = (state == CAPT) && !fifo_underflow;

  piso_shreg #(
    .WIDTH(FIFO_WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (handshake),
    .din      (fifo_data_out),
    .msb      (ser_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fifo_rd_en    <= 1'b0;
      ser_valid     <= 1'b0;
      ser_last      <= 1'b0;
      busy          <= 1'b0;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      underflow_err <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;

      // A fresh underflow takes priority over a simultaneous clear.
      if (state == CAPT && fifo_underflow) begin
        underflow_err <= 1'b1;
      end else if (err_clr) begin
        underflow_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state      <= READ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          if (fifo_underflow) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            bit_cnt   <= BCW'(FIFO_WIDTH - 1);
            ser_valid <= 1'b1;
            ser_last  <= (FIFO_WIDTH == 1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // ser_last is registered, so it is computed one bit ahead of bit_cnt reaching 0.
          if (ser_ready) begin
            if (bit_cnt == '0) begin
              word_cnt  <= word_cnt + 1'b1;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
              ser_last <= (bit_cnt == BCW'(1));
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Scoreboard bench: a FIFO model feeds the serializer, a negedge monitor checks every delivered bit.
module tb_fifo_drain_serializer;

  localparam int W  = 16;
  localparam int CW = 8;

  typedef struct packed {
    logic bit_v;
    logic last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic          fifo_rd_en;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_ready = 1'b1;
  logic          ser_last;
  logic          busy;
  logic [CW-1:0] word_cnt;
  logic          underflow_err;
  logic          err_clr;

  logic [W-1:0] fifo_q[$];
  logic         push_req = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         flush_req = 1'b0;
  logic         force_uf = 1'b0;
  bit           rand_ready = 1'b0;
  bit           ready_fix = 1'b1;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rd_cnt = 0;
  int   hs_cnt = 0;
  bit   prev_stall = 1'b0;
  logic held_out, held_last;
  bit   gap_active = 1'b0;
  bit   gap_check_en = 1'b0;
  int   gap_cnt = 0;

  always #5 clk = ~clk;

  fifo_drain_serializer #(
    .FIFO_WIDTH(W),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .ser_out        (ser_out),
    .ser_valid      (ser_valid),
    .ser_ready      (ser_ready),
    .ser_last       (ser_last),
    .busy           (busy),
    .word_cnt       (word_cnt),
    .underflow_err  (underflow_err),
    .err_clr        (err_clr)
  );

  // FIFO model: read data and underflow become valid the cycle after fifo_rd_en.
  always @(posedge clk) begin
    if (flush_req) fifo_q.delete();
    if (fifo_rd_en) begin
      if (force_uf || fifo_q.size() == 0) begin
        fifo_underflow <= 1'b1;
      end else begin
        fifo_data_out  <= fifo_q.pop_front();
        fifo_underflow <= 1'b0;
      end
    end else begin
      fifo_underflow <= 1'b0;
    end
    if (push_req) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    ser_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      gap_active = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (prev_stall) begin
        chk("stall_valid", ser_valid, 1);
        chk("stall_out", ser_out, held_out);
        chk("stall_last", ser_last, held_last);
      end
      if (ser_valid && gap_active) begin
        gap_active = 1'b0;
        if (gap_check_en) chk("gap", gap_cnt, 3);
      end
      if (ser_valid && ser_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bit: got bit %0b, expected no bit", ser_out);
        end else begin
          e = exp_q.pop_front();
          chk("bit", ser_out, e.bit_v);
          chk("last", ser_last, e.last);
        end
        if (ser_last) begin
          gap_active = 1'b1;
          gap_cnt    = 0;
        end
      end else if (!ser_valid && gap_active) begin
        gap_cnt++;
      end
      prev_stall = ser_valid && !ser_ready;
      held_out   = ser_out;
      held_last  = ser_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit exp_it);
    push_data = w;
    push_req  = 1'b1;
    tick();
    push_req = 1'b0;
    if (exp_it) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back('{bit_v: w[i], last: (i == 0)});
    end
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || fifo_rd_en || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic wait_hs(input string name, input int target);
    int n = 0;
    while (hs_cnt < target && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: handshakes %0d, expected %0d", name, hs_cnt, target);
    end
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!fifo_rd_en && n < 10) begin
      tick();
      n++;
    end
    chk(name, fifo_rd_en, 1);
  endtask

  initial begin
    int b_rd, b_hs, n;
    logic [W-1:0] words [8];
    words = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD, 16'h5A5A, 16'hC3A5};
    rst_n   = 1'b0;
    enable  = 1'b0;
    err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single word, ready always high, with first-bit latency
    push_word(16'hA5C3, 1'b1);
    tick();
    b_rd = rd_cnt; b_hs = hs_cnt;
    enable = 1'b1;
    n = 0;
    while (!ser_valid && n < 10) begin
      tick();
      n++;
    end
    chk("latency", n, 3);
    wait_done("t2", 100);
    chk("t2_rd", rd_cnt - b_rd, 1);
    chk("t2_hs", hs_cnt - b_hs, 16);
    chk("t2_cnt", word_cnt, 1);

    // Same word with random back-pressure
    rand_ready = 1'b1;
    b_rd = rd_cnt; b_hs = hs_cnt;
    push_word(16'hA5C3, 1'b1);
    wait_done("t3", 400);
    rand_ready = 1'b0;
    chk("t3_rd", rd_cnt - b_rd, 1);
    chk("t3_hs", hs_cnt - b_hs, 16);
    chk("t3_cnt", word_cnt, 2);

    // Eight back-to-back words
    enable = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) push_word(words[i], 1'b1);
    b_rd = rd_cnt; b_hs = hs_cnt;
    enable = 1'b1;
    wait_hs("t4_first", b_hs + 1);
    gap_check_en = 1'b1;
    wait_done("t4", 600);
    gap_check_en = 1'b0;
    repeat (5) tick();
    chk("t4_rd", rd_cnt - b_rd, 8);
    chk("t4_hs", hs_cnt - b_hs, 128);
    chk("t4_cnt", word_cnt, 10);
    chk("t4_busy", busy, 0);

    // enable dropped mid-word
    enable = 1'b0;
    push_word(16'h3C96, 1'b1);
    push_word(16'h1111, 1'b0);
    push_word(16'h2222, 1'b0);
    b_rd = rd_cnt; b_hs = hs_cnt;
    enable = 1'b1;
    wait_hs("t5_bit5", b_hs + 5);
    enable = 1'b0;
    wait_done("t5", 100);
    repeat (4) tick();
    chk("t5_rd", rd_cnt - b_rd, 1);
    chk("t5_hs", hs_cnt - b_hs, 16);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", word_cnt, 11);
    flush();

    // Asynchronous reset mid-word
    b_hs = hs_cnt;
    push_word(16'hF00F, 1'b1);
    enable = 1'b1;
    wait_hs("t1_bits", b_hs + 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rd_en", fifo_rd_en, 0);
    chk("t1_out", ser_out, 0);
    chk("t1_valid", ser_valid, 0);
    chk("t1_last", ser_last, 0);
    chk("t1_busy", busy, 0);
    chk("t1_cnt", word_cnt, 0);
    chk("t1_err", underflow_err, 0);
    exp_q.delete();
    push_word(16'h7777, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_pop", fifo_rd_en, 0);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    flush();
    chk("t1_cnt_after", word_cnt, 0);

    // Forced underflow, clear, then set-beats-clear
    push_word(16'h1234, 1'b0);
    force_uf = 1'b1;
    b_rd = rd_cnt; b_hs = hs_cnt;
    enable = 1'b1;
    wait_rd("t6_rd");
    enable = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("t6_err", underflow_err, 1);
    chk("t6_busy", busy, 0);
    chk("t6_valid", ser_valid, 0);
    chk("t6_hs", hs_cnt - b_hs, 0);
    chk("t6_rdn", rd_cnt - b_rd, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_clr", underflow_err, 0);
    enable = 1'b1;
    wait_rd("t6_rd2");
    enable = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_set_wins", underflow_err, 1);
    force_uf = 1'b0;
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
